// File: rtl/fifo_serial_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_serial_reader_if
//  Description : Bundle of FIFO read-side handshake signals and serial
//                output signals for fifo_serial_reader. The master modport
//                is the reader; the slave modport is the surrounding system
//                (FIFO plus line consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_serial_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  run;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  en_rd;
    logic                  tx;
    logic                  busy;
    logic [3:0]            word_cnt;

    modport master (
        input  run,
        input  empty,
        input  rd_data,
        output en_rd,
        output tx,
        output busy,
        output word_cnt
    );

    modport slave (
        output run,
        output empty,
        output rd_data,
        input  en_rd,
        input  tx,
        input  busy,
        input  word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_serial_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_serial_reader
//  Description : Drains words from a FIFO while run is high and sends each
//                one as a UART-style frame: start bit (0), DATA_WIDTH data
//                bits LSB first, optional even-parity bit, stop bit (1).
//                Every bit lasts BIT_CYCLES clocks. tx, en_rd and busy are
//                registered. Reset (rst) is asynchronous, active-low.
//  Options     : define FIFO_READER_PARITY_EN to insert the parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fifo_serial_reader_if.master   bus
);

    // Counter widths cover the largest value each counter must hold.
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CYC_W-1:0] c_cyc_last = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_READER_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    tx_q, tx_d;
    logic                    en_rd_q, en_rd_d;
    logic                    busy_q, busy_d;
`ifdef FIFO_READER_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic                    w_cyc_last;

    assign w_cyc_last = (cyc_q == c_cyc_last);

    // Next-state logic; outputs are derived from the next state so the
    // registered tx/en_rd/busy line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
`ifdef FIFO_READER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                // run and empty are only looked at here, so a mid-frame
                // change of either never affects the frame in flight.
                if (bus.run && !bus.empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // FIFO data is valid the cycle after the en_rd pulse.
                shift_d  = bus.rd_data;
`ifdef FIFO_READER_PARITY_EN
                parity_d = ^bus.rd_data;
`endif
                cyc_d    = '0;
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (w_cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cyc_last) begin
                    cyc_d = '0;
                    if (bit_q == c_bit_last) begin
                        bit_d   = '0;
`ifdef FIFO_READER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef FIFO_READER_PARITY_EN
            S_PARITY: begin
                if (w_cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cyc_last) begin
                    cyc_d   = '0;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        en_rd_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_READER_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            en_rd_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FIFO_READER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            en_rd_q  <= en_rd_d;
            busy_q   <= busy_d;
`ifdef FIFO_READER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx       = tx_q;
    assign bus.en_rd    = en_rd_q;
    assign bus.busy     = busy_q;
    assign bus.word_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_serial_reader
//  Description : Directed self-checking bench for fifo_serial_reader with
//                DATA_WIDTH=8, BIT_CYCLES=4 and a small queue-based FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_reader;

    localparam int DW = 8;
    localparam int BC = 4;
`ifdef FIFO_READER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int N = FB * BC;     // frame length in clocks

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_serial_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_serial_reader #(
        .DATA_WIDTH (DW),
        .BIT_CYCLES (BC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIFO model: pops on en_rd, data held until next pop.
    logic [7:0] fq[$];
    logic       f_empty   = 1'b1;
    logic [7:0] f_rd_data = 8'h00;
    assign bus.empty   = f_empty;
    assign bus.rd_data = f_rd_data;

    always @(negedge clk) begin
        if (bus.en_rd && fq.size() > 0) f_rd_data = fq.pop_front();
        f_empty = (fq.size() == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;
    int pop_t   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame_stream(input logic [7:0] d);
        logic [FB-1:0] fb;
        logic [63:0]   s;
        fb       = '0;
        s        = '0;
        fb[0]    = 1'b0;
        for (int j = 0; j < DW; j++) fb[1+j] = d[j];
`ifdef FIFO_READER_PARITY_EN
        fb[DW+1] = ^d;
`endif
        fb[FB-1] = 1'b1;
        for (int i = 0; i < N; i++) s[i] = fb[i / BC];
        return s;
    endfunction

    task automatic wait_pop(output bit got);
        got = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (bus.en_rd) begin
                got   = 1'b1;
                pop_t = cyc;
                break;
            end
        end
        if (!got) chk("pop_timeout", 64'd0, 64'd1);
    endtask

    // Follows one frame from its POP cycle (k=0) to the IDLE cycle after it.
    task automatic run_frame(input logic [7:0] d, input int drop_k, output logic [63:0] obs);
        bit got;
        int nbusy;
        int npop;
        obs   = '0;
        nbusy = 0;
        npop  = 0;
        wait_pop(got);
        if (!got) return;
        for (int k = 0; k <= N + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy)  nbusy++;
            if (bus.en_rd) npop++;
            if (k >= 2 && k < N + 2) obs[k-2] = bus.tx;
            if (k == drop_k) bus.run = 1'b0;
        end
        exp_cnt = (exp_cnt + 1) % 16;
        chk("tx_stream",   obs, frame_stream(d));
        chk("busy_cycles", 64'(nbusy), 64'(N + 2));
        chk("pop_count",   64'(npop), 64'd1);
        chk("word_cnt",    64'(bus.word_cnt), 64'(exp_cnt));
        chk("tx_idle",     64'(bus.tx), 64'd1);
    endtask

    logic [63:0] obs;
    logic [7:0]  bits;
    int          t0, t1, t2, n_pop, n_busy, n_low;
    bit          got;

    initial begin
        bus.run = 1'b0;

        // Reset state
        #12;
        chk("rst_tx",    64'(bus.tx), 64'd1);
        chk("rst_en_rd", 64'(bus.en_rd), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_cnt",   64'(bus.word_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Empty hold-off
        bus.run = 1'b1;
        n_pop = 0; n_busy = 0; n_low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.en_rd) n_pop++;
            if (bus.busy)  n_busy++;
            if (!bus.tx)   n_low++;
        end
        chk("holdoff_pop",  64'(n_pop), 64'd0);
        chk("holdoff_busy", 64'(n_busy), 64'd0);
        chk("holdoff_tx",   64'(n_low), 64'd0);

        // Single word 0xA5
        fq.push_back(8'hA5);
        run_frame(8'hA5, -1, obs);
        for (int j = 0; j < DW; j++) bits[j] = obs[BC + BC*j + 1];
        chk("a5_data_lsb_first", 64'(bits), 64'hA5);
        chk("a5_start", 64'(obs[0]), 64'd0);

        // Back-to-back 0x01, 0xFF, 0x80
        fq.push_back(8'h01);
        fq.push_back(8'hFF);
        fq.push_back(8'h80);
        run_frame(8'h01, -1, obs); t0 = pop_t;
        run_frame(8'hFF, -1, obs); t1 = pop_t;
        run_frame(8'h80, -1, obs); t2 = pop_t;
        chk("b2b_gap1", 64'(t1 - t0), 64'(N + 3));
        chk("b2b_gap2", 64'(t2 - t1), 64'(N + 3));
        chk("b2b_cnt",  64'(bus.word_cnt), 64'd4);

`ifdef FIFO_READER_PARITY_EN
        // Parity bit sits right after the eight data bits
        fq.push_back(8'h07);
        run_frame(8'h07, -1, obs);
        chk("parity_07", 64'(obs[(DW+1)*BC + 1]), 64'd1);
        fq.push_back(8'h03);
        run_frame(8'h03, -1, obs);
        chk("parity_03", 64'(obs[(DW+1)*BC + 1]), 64'd0);
`endif

        // Abort by reset during data bit 3 (k=18..21)
        fq.push_back(8'h3C);
        wait_pop(got);
        repeat (19) @(negedge clk);
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk("abort_tx",    64'(bus.tx), 64'd1);
        chk("abort_busy",  64'(bus.busy), 64'd0);
        chk("abort_cnt",   64'(bus.word_cnt), 64'd0);
        chk("abort_en_rd", 64'(bus.en_rd), 64'd0);
        fq.push_back(8'h55);
        n_pop = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.en_rd) n_pop++;
        end
        bus.run = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.en_rd) n_pop++;
        end
        chk("abort_no_pop", 64'(n_pop), 64'd0);
        bus.run = 1'b1;
        run_frame(8'h55, -1, obs);

        // Run drop during START: frame completes, no further pop
        fq.push_back(8'h5A);
        fq.push_back(8'h11);
        run_frame(8'h5A, 3, obs);
        n_pop = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.en_rd) n_pop++;
        end
        chk("rundrop_no_pop", 64'(n_pop), 64'd0);
        chk("rundrop_cnt",    64'(bus.word_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
